// File: rtl/gshare_predictor.sv
// gshare branch predictor: PHT sweep-init, speculative history, mispredict repair.
// Optional return address stack is built when GSHARE_RAS_EN is defined.
module gshare_predictor #(
  parameter int PHT_ADDR_BITS = 6,
  parameter int HIST_BITS     = 3,
  parameter int CTR_BITS      = 2,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
`ifdef GSHARE_RAS_EN
  input  logic                     r_push,
  input  logic                     r_pop,
  input  logic [31:0]              r_addr,
  output logic [31:0]              r_top,
  output logic                     r_valid,
`endif
  output logic                     ready,
  input  logic                     p_valid,
  input  logic [31:0]              p_pc,
  output logic                     p_taken,
  output logic [PHT_ADDR_BITS-1:0] p_index,
  output logic [HIST_BITS-1:0]     p_hist,
  input  logic                     u_valid,
  input  logic [PHT_ADDR_BITS-1:0] u_index,
  input  logic [HIST_BITS-1:0]     u_hist,
  input  logic                     u_taken,
  input  logic                     u_mispredict
);

  localparam int PHT_SIZE = 1 << PHT_ADDR_BITS;
  localparam logic [CTR_BITS-1:0] WNT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                    state;
  state_t                    state_nx;
  logic [PHT_ADDR_BITS-1:0]  init_cnt;
  logic [HIST_BITS-1:0]      gh;
  logic [CTR_BITS-1:0]       pht [PHT_SIZE];
  logic [PHT_ADDR_BITS-1:0]  gh_ext;
  logic [HIST_BITS:0]        spec_cat;
  logic [HIST_BITS:0]        fix_cat;
  logic [CTR_BITS-1:0]       ctr;
  logic [CTR_BITS-1:0]       ctr_nx;
  logic                      unused_bits;

  assign ready   = (state == RUN);
  assign gh_ext  = PHT_ADDR_BITS'(gh) << (PHT_ADDR_BITS - HIST_BITS);
  assign p_index = p_pc[PHT_ADDR_BITS+1:2] ^ gh_ext;
  assign p_taken = ready & pht[p_index][CTR_BITS-1];
  assign p_hist  = gh;

  // Newest outcome enters at the MSB; the oldest bit falls off bit 0.
  assign spec_cat = {p_taken, gh};
  assign fix_cat  = {u_taken, u_hist};

  assign unused_bits = ^{p_pc[31:PHT_ADDR_BITS+2], p_pc[1:0],
                         spec_cat[0], fix_cat[0]};

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (init_cnt == '1) state_nx = RUN;
      RUN:  state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Repair wins: a same-cycle predicted branch is on the wrong path.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gh <= '0;
    end else if (state == RUN) begin
      if (u_valid && u_mispredict) gh <= fix_cat[HIST_BITS:1];
      else if (p_valid)            gh <= spec_cat[HIST_BITS:1];
    end
  end

  always_comb begin
    ctr    = pht[u_index];
    ctr_nx = ctr;
    if (u_taken && ctr != '1)       ctr_nx = ctr + CTR_BITS'(1);
    else if (!u_taken && ctr != '0) ctr_nx = ctr - CTR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == INIT)  pht[init_cnt] <= WNT;
      else if (u_valid)   pht[u_index]  <= ctr_nx;
    end
  end

`ifdef GSHARE_RAS_EN
  localparam int RP = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC = $clog2(RAS_DEPTH + 1);
  localparam logic [RC-1:0] RFULL = RC'(RAS_DEPTH);

  logic [31:0]   ras [RAS_DEPTH];
  logic [RP-1:0] rptr;
  logic [RP-1:0] rptr_inc;
  logic [RC-1:0] rcnt;

  assign rptr_inc = rptr + 1'b1;
  assign r_valid  = (rcnt != '0);
  assign r_top    = r_valid ? ras[rptr] : '0;

  // Circular pointer: a push when full silently overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr <= '0;
      rcnt <= '0;
    end else if (r_push && !r_pop) begin
      rptr <= rptr_inc;
      if (rcnt != RFULL) rcnt <= rcnt + 1'b1;
    end else if (r_pop && !r_push && rcnt != '0) begin
      rptr <= rptr - 1'b1;
      rcnt <= rcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      if (r_push && r_pop) ras[rptr]     <= r_addr;
      else if (r_push)     ras[rptr_inc] <= r_addr;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised and directed bench for gshare_predictor against a behavioural model.
// Define GSHARE_RAS_EN to also exercise the return address stack.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ready;
  logic        p_valid;
  logic [31:0] p_pc;
  logic        p_taken;
  logic [5:0]  p_index;
  logic [2:0]  p_hist;
  logic        u_valid;
  logic [5:0]  u_index;
  logic [2:0]  u_hist;
  logic        u_taken;
  logic        u_mispredict;
`ifdef GSHARE_RAS_EN
  logic        r_push;
  logic        r_pop;
  logic [31:0] r_addr;
  logic [31:0] r_top;
  logic        r_valid;
`endif

  always #5 clk = ~clk;

  gshare_predictor dut (
    .clk(clk),
    .resetn(resetn),
`ifdef GSHARE_RAS_EN
    .r_push(r_push),
    .r_pop(r_pop),
    .r_addr(r_addr),
    .r_top(r_top),
    .r_valid(r_valid),
`endif
    .ready(ready),
    .p_valid(p_valid),
    .p_pc(p_pc),
    .p_taken(p_taken),
    .p_index(p_index),
    .p_hist(p_hist),
    .u_valid(u_valid),
    .u_index(u_index),
    .u_hist(u_hist),
    .u_taken(u_taken),
    .u_mispredict(u_mispredict)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model: counters as plain ints, history as a 3-bit int.
  int pht_m [64];
  int gh_m    = 0;
  bit ready_m = 0;
  int swept   = 0;

  function automatic int idx_m(input logic [31:0] pc);
    return int'(((pc >> 2) ^ (gh_m << 3)) & 63);
  endfunction

  function automatic bit pred_m(input logic [31:0] pc);
    return ready_m && (pht_m[idx_m(pc)] >= 2);
  endfunction

  function automatic void model_edge();
    bit pt;
    if (!resetn) begin
      ready_m = 0;
      swept   = 0;
      gh_m    = 0;
    end else if (!ready_m) begin
      pht_m[swept] = 1;
      swept++;
      if (swept == 64) ready_m = 1;
    end else begin
      pt = pred_m(p_pc);
      if (u_valid) begin
        if (u_taken) pht_m[u_index] = (pht_m[u_index] == 3) ? 3 : pht_m[u_index] + 1;
        else         pht_m[u_index] = (pht_m[u_index] == 0) ? 0 : pht_m[u_index] - 1;
      end
      if (u_valid && u_mispredict) gh_m = (int'(u_taken) << 2) | (int'(u_hist) >> 1);
      else if (p_valid)            gh_m = (int'(pt) << 2) | (gh_m >> 1);
    end
  endfunction

  task automatic cycle();
    #1;
    chk("ready", ready, ready_m);
    chk("p_taken", p_taken, pred_m(p_pc));
    chk("p_index", p_index, idx_m(p_pc));
    chk("p_hist", p_hist, gh_m);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic measure_init();
    int lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      cycle();
      lat++;
    end
    chk("init_latency", lat, 64);
  endtask

  task automatic idle_inputs();
    p_valid = 0; p_pc = 0;
    u_valid = 0; u_index = 0; u_hist = 0;
    u_taken = 0; u_mispredict = 0;
`ifdef GSHARE_RAS_EN
    r_push = 0; r_pop = 0; r_addr = 0;
`endif
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_hist", p_hist, 0);
`ifdef GSHARE_RAS_EN
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_top", r_top, 0);
`endif
    resetn = 1;
    measure_init();

    for (int i = 0; i < 64; i++) begin
      p_pc = 32'(i << 2);
      #1 chk("init_pred", p_taken, 0);
      cycle();
    end

    // Training and saturation on index 5 with GH = 0.
    p_pc = 32'h14; u_valid = 1; u_index = 5; u_taken = 1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) u_taken = 0;
      cycle();
      if (i == 2) chk("train_pred_after2", p_taken, 1);
      if (i == 5) chk("train_pred_after5", p_taken, 0);
    end

    // Preset entry 0 to strongly taken, then speculate.
    u_index = 0; u_taken = 1;
    repeat (2) cycle();
    u_valid = 0; p_valid = 1; p_pc = 32'h0;
    #1;
    chk("spec_taken", p_taken, 1);
    chk("spec_hist_before", p_hist, 0);
    cycle();
    p_valid = 0; p_pc = 32'h40;
    #1;
    chk("spec_hist_after", p_hist, 3'b100);
    chk("spec_index", p_index, 6'h30);
    cycle();

    // Repair overrides a same-cycle speculative shift.
    p_valid = 1; u_valid = 1; u_mispredict = 1;
    u_hist = 3'b011; u_taken = 0; u_index = 9;
    cycle();
    idle_inputs();
    #1 chk("repair_hist", p_hist, 3'b001);
    cycle();

`ifdef GSHARE_RAS_EN
    begin
      logic [31:0] pushes [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
      logic [31:0] tops   [3] = '{32'h10C, 32'h108, 32'h104};
      r_push = 1;
      for (int i = 0; i < 5; i++) begin
        r_addr = pushes[i];
        cycle();
      end
      r_push = 0;
      chk("ras_top_full", r_top, 32'h110);
      r_pop = 1;
      for (int i = 0; i < 4; i++) begin
        cycle();
        if (i < 3) chk("ras_pop_top", r_top, tops[i]);
        else       chk("ras_empty", r_valid, 0);
      end
      r_pop = 0;
    end
`endif

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      resetn       = ($urandom_range(0, 999) != 0);
      p_valid      = $urandom_range(0, 1) == 1;
      p_pc         = $urandom;
      u_valid      = $urandom_range(0, 1) == 1;
      u_index      = 6'($urandom);
      u_hist       = 3'($urandom);
      u_taken      = $urandom_range(0, 1) == 1;
      u_mispredict = $urandom_range(0, 3) == 0;
      cycle();
    end
    idle_inputs();

    // Reset in the middle of the initialisation sweep.
    resetn = 0;
    cycle();
    resetn = 1;
    repeat (20) cycle();
    chk("midinit_not_ready", ready, 0);
    resetn = 0;
    cycle();
    resetn = 1;
    measure_init();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
